// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a valid/ready request port.
// Each request is held for a fixed WAIT cycles, then answered with a
// one-cycle response strobe. A separate debug port exposes the registered
// memory word at dbg_addr every cycle.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Everything about a request that must survive past the accept edge
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [1:0]        ofs;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        in_req;
  req_t        held_req;
  req_t        cur;
  logic [31:0] mem [DEPTH];
  logic        accept;
  logic        enter_resp;
  logic        aligned;
  logic        do_write;
  logic        unused_hi;

  // Bits above the word index only alias; they are intentionally dropped
  assign unused_hi = ^req_addr[31:ADDR_W+2];

  assign in_req = '{we:    req_we,
                    idx:   req_addr[ADDR_W+1:2],
                    wdata: req_wdata,
                    be:    req_be,
                    ofs:   req_addr[1:0]};

  assign req_ready = (state == S_IDLE);
  assign accept    = req_ready && req_valid;

  // With WAIT = 0 the response is produced on the accept edge itself, so the
  // live request is used; otherwise the copy captured at accept is used.
  assign cur        = (state == S_IDLE) ? in_req : held_req;
  assign enter_resp = (accept && (WAIT_CNT == 4'd0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1));
  assign aligned    = (cur.ofs == 2'b00);
  assign do_write   = !rst && enter_resp && cur.we && aligned;

  // Capture the request on accept; later input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (!rst && accept) held_req <= in_req;
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (WAIT_CNT == 4'd0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_CNT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Loads sample the word on the same edge a store would commit
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !aligned;
        rsp_rdata <= (aligned && !cur.we) ? mem[cur.idx] : 32'd0;
      end
    end
  end

  // Byte-lane store commit; memory contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cur.be[i]) mem[cur.idx][8*i +: 8] <= cur.wdata[8*i +: 8];
      end
    end
  end

  // Debug read port: read-before-write against a same-edge store
  always_ff @(posedge clk) begin
    if (rst) dbg_data <= 32'd0;
    else     dbg_data <= mem[dbg_addr];
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory depth is 2**ADDR_W words of 32 bits.
REQ-002 Parameter WAIT, default 2, wait cycles between request accept and response; legal range 0..15.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset is synchronous and active-high.
REQ-005 req_valid  input  1  CPU presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i enables byte lane [8i+7:8i].
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  load data, valid while rsp_valid = 1.
REQ-013 rsp_err  output  1  misaligned-access flag, valid while rsp_valid = 1.
REQ-014 dbg_addr  input  ADDR_W  debug word address (display/switch port).
REQ-015 dbg_data  output  32  registered memory word at dbg_addr.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept occurs on a rising edge where the FSM is in IDLE and req_valid = 1; we, word index, wdata, be and addr[1:0] are latched at that edge.
REQ-018 On accept: if WAIT = 0, go to RESP; otherwise go to WAIT with a counter loaded with WAIT.
REQ-019 In WAIT the counter decrements each cycle; the transition to RESP occurs on the edge where the counter equals 1.
REQ-020 rsp_valid SHALL be 1 for exactly the one cycle spent in RESP, which is WAIT+1 cycles after the accept edge; RESP always returns to IDLE on the next edge.
REQ-021 There is no response back-pressure; the response is never held or repeated.
REQ-022 Misaligned access (latched addr[1:0] != 0): rsp_err = 1, rsp_rdata = 0, memory unchanged.
REQ-023 Aligned store: commit on the edge entering RESP, writing only lanes with be = 1; be = 4'b0000 leaves memory unchanged and still responds; rsp_rdata = 0, rsp_err = 0.
REQ-024 Aligned load: rsp_rdata = full 32-bit word at the latched index as of the RESP cycle; be is ignored; rsp_err = 0.
REQ-025 Outside RESP: rsp_rdata = 0 and rsp_err = 0.
REQ-026 Back-to-back requests: the earliest next accept is the IDLE cycle after RESP; throughput is one request per WAIT+2 cycles.
REQ-027 req_* inputs are ignored outside IDLE; changes to them after accept do not affect the transaction in flight.
REQ-028 dbg_data SHALL update every cycle to mem[dbg_addr] with one-cycle latency.
REQ-029 Same-edge store commit and debug read of the same word: dbg_data returns the pre-write value (read-before-write); the new value appears one cycle later.
REQ-030 Address bits above ADDR_W+1 are ignored; addresses wrap modulo the memory depth.

Reset
REQ-031 With rst = 1 at a rising edge: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, dbg_data = 0.
REQ-032 Reset does not clear memory contents.
REQ-033 Reset mid-transaction (in WAIT) discards the transaction; no store is committed and no response is issued.
REQ-034 Reset in the cycle of an accept edge takes priority; no request is accepted.

Verification
REQ-035 WAIT=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> each rsp_valid appears 3 cycles after its accept; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-036 Partial store: store 0x11223344 to 0x20 with be 4'hF, then be 4'b0101 with wdata 0xAABBCCDD -> load of 0x20 returns 0x11BB33DD.
REQ-037 Misaligned: load 0x22 -> rsp_err = 1 and rsp_rdata = 0; a subsequent store to 0x21 leaves word 0x20 unchanged.
REQ-038 req_valid held high for 3 consecutive requests -> accepts exactly WAIT+2 cycles apart; req_ready = 0 between accepts.
REQ-039 rst pulsed while in WAIT during a store of 0x5 to 0x30 -> no rsp_valid, word 0x30 unchanged, req_ready = 1 in the cycle after reset.
REQ-040 dbg_addr = 12 while a store of 0xCAFEF00D to 0x30 commits -> dbg_data shows the old value on that edge and 0xCAFEF00D one cycle later.
